// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding word read on the instruction bus,
// a small FIFO of {pc, instr} entries, and redirect handling that drains in-flight reads.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0200,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic          done;
  logic          push;
  logic          pop;
  logic [31:0]   target;

  // DRAIN always keeps the request up: fetch_pc is frozen there, so the address holds too.
  always_comb begin
    imem_ren    = nRST && ((state == DRAIN) || (count != FULL));
    imem_addr   = fetch_pc;
    done        = imem_ren && !imem_busy;
    push        = done && (state == RUN) && !redirect;
    instr_valid = (count != '0);
    pop         = instr_valid && !stall && !redirect;
    target      = redirect_pc & ~32'h3;
    instr       = instr_valid ? q_instr[rd_ptr] : NOP_INSTR;
    instr_pc    = instr_valid ? q_pc[rd_ptr]    : 32'h0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      pending_pc <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            if (imem_ren && imem_busy) begin
              state      <= DRAIN;
              pending_pc <= target;
            end else begin
              fetch_pc <= target;
            end
          end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        DRAIN: begin
          // The drained word is dropped; a redirect landing on the same cycle is the newest target.
          if (done) begin
            fetch_pc <= redirect ? target : pending_pc;
            state    <= RUN;
          end else if (redirect) begin
            pending_pc <= target;
          end
        end
        default: state <= RUN;
      endcase

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a directed cycle table for the corner cases, then random
// bus/stall/redirect/reset traffic checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0200;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .imem_ren(imem_ren),
    .imem_addr(imem_addr),
    .imem_busy(imem_busy),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          nrst;
    bit          busy;
    bit          stall;
    bit          redir;
    logic [31:0] rpc;
    bit          e_ren;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t vecs[$];

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_pending;
  bit          m_drain;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void add_vec(input bit nrst, input bit busy, input bit stl, input bit redir,
                                  input logic [31:0] rpc, input bit e_ren, input logic [31:0] e_addr,
                                  input bit e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.nrst = nrst; v.busy = busy; v.stall = stl; v.redir = redir; v.rpc = rpc;
    v.e_ren = e_ren; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    vecs.push_back(v);
  endfunction

  // Row expectations describe the outputs seen during the cycle the row's inputs are applied.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    @(negedge CLK);
    nRST        = v.nrst;
    imem_busy   = v.busy;
    stall       = v.stall;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    imem_rdata  = word(v.e_addr);
    #1;
    tag = $sformatf("vec%0d", idx);
    check_output({tag, ".imem_ren"}, {31'b0, imem_ren}, {31'b0, v.e_ren});
    check_output({tag, ".imem_addr"}, imem_addr, v.e_addr);
    check_output({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, v.e_valid});
    check_output({tag, ".instr_pc"}, instr_pc, v.e_pc);
    check_output({tag, ".instr"}, instr, v.e_valid ? word(v.e_pc) : NOP);
  endtask

  // Reference model: a FIFO of fetched words plus the next fetch address and a drain flag.
  task automatic model_step();
    bit          ren;
    bit          done;
    logic [31:0] tgt;
    ent_t        e;
    if (!nRST) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_drain = 0;
      return;
    end
    ren  = m_drain || (m_q.size() < DEPTH);
    done = ren && !imem_busy;
    tgt  = redirect_pc & 32'hFFFF_FFFC;
    if (redirect) begin
      m_q.delete();
      if (m_drain) begin
        if (done) begin
          m_pc    = tgt;
          m_drain = 0;
        end else begin
          m_pending = tgt;
        end
      end else if (ren && imem_busy) begin
        m_drain   = 1;
        m_pending = tgt;
      end else begin
        m_pc = tgt;
      end
    end else if (m_drain) begin
      if (done) begin
        m_pc    = m_pending;
        m_drain = 0;
      end
    end else begin
      if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
      if (done) begin
        e.pc  = m_pc;
        e.ins = imem_rdata;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_model(input int cyc);
    bit          e_ren;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    string       tag;
    e_ren   = nRST && (m_drain || (m_q.size() < DEPTH));
    e_valid = (m_q.size() != 0);
    e_instr = e_valid ? m_q[0].ins : NOP;
    e_pc    = e_valid ? m_q[0].pc : 32'h0;
    tag = $sformatf("rnd%0d", cyc);
    check_output({tag, ".imem_ren"}, {31'b0, imem_ren}, {31'b0, e_ren});
    check_output({tag, ".imem_addr"}, imem_addr, m_pc);
    check_output({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
    check_output({tag, ".instr_pc"}, instr_pc, e_pc);
    check_output({tag, ".instr"}, instr, e_instr);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST      = 1'b0;
    imem_busy = 1'b0;
    stall     = 1'b0;
    redirect  = 1'b0;
    @(posedge CLK);
  endtask

  initial begin
    nRST        = 1'b0;
    imem_busy   = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;

    // Reset release, zero-wait bus, no stall
    add_vec(1,0,0,0,32'h0,        1,32'h200,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h204,1'b1,32'h200);
    add_vec(1,0,0,0,32'h0,        1,32'h208,1'b1,32'h204);
    add_vec(0,0,0,0,32'h0,        0,32'h20C,1'b1,32'h208);
    // Stall for 10 cycles: four completions, then the request drops
    add_vec(1,0,1,0,32'h0,        1,32'h200,1'b0,32'h0);
    add_vec(1,0,1,0,32'h0,        1,32'h204,1'b1,32'h200);
    add_vec(1,0,1,0,32'h0,        1,32'h208,1'b1,32'h200);
    add_vec(1,0,1,0,32'h0,        1,32'h20C,1'b1,32'h200);
    for (int i = 0; i < 6; i++)
      add_vec(1,0,1,0,32'h0,      0,32'h210,1'b1,32'h200);
    add_vec(1,0,0,0,32'h0,        0,32'h210,1'b1,32'h200);
    add_vec(1,0,1,0,32'h0,        1,32'h210,1'b1,32'h204);
    // Redirect with the request down (queue full)
    add_vec(1,0,1,1,32'h3000,     0,32'h214,1'b1,32'h204);
    add_vec(1,0,0,0,32'h0,        1,32'h3000,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h3004,1'b1,32'h3000);
    add_vec(1,0,1,0,32'h0,        1,32'h3008,1'b1,32'h3004);
    // Redirect to 0x1003 with 2 entries queued, bus not busy
    add_vec(1,0,1,1,32'h1003,     1,32'h300C,1'b1,32'h3004);
    add_vec(1,0,0,0,32'h0,        1,32'h1000,1'b0,32'h0);
    // Redirect during a busy request, then a second redirect while draining
    add_vec(1,1,1,0,32'h0,        1,32'h1004,1'b1,32'h1000);
    add_vec(1,1,1,1,32'h400,      1,32'h1004,1'b1,32'h1000);
    add_vec(1,1,0,0,32'h0,        1,32'h1004,1'b0,32'h0);
    add_vec(1,1,0,1,32'h800,      1,32'h1004,1'b0,32'h0);
    add_vec(1,1,0,0,32'h0,        1,32'h1004,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h1004,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h800,1'b0,32'h0);
    // Redirect to the top of the address space, low bits masked
    add_vec(1,0,0,1,32'hFFFF_FFFE,1,32'h804,1'b1,32'h800);
    add_vec(1,0,0,0,32'h0,        1,32'hFFFF_FFFC,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h0,1'b1,32'hFFFF_FFFC);
    add_vec(1,0,0,0,32'h0,        1,32'h4,1'b1,32'h0);
    // Reset mid-transaction with 3 entries queued
    add_vec(1,0,1,0,32'h0,        1,32'h8,1'b1,32'h4);
    add_vec(1,0,1,0,32'h0,        1,32'hC,1'b1,32'h4);
    add_vec(1,1,1,0,32'h0,        1,32'h10,1'b1,32'h4);
    add_vec(0,1,1,0,32'h0,        0,32'h10,1'b1,32'h4);
    add_vec(1,1,0,0,32'h0,        1,32'h200,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h200,1'b0,32'h0);
    add_vec(1,0,0,0,32'h0,        1,32'h204,1'b1,32'h200);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_output("reset.imem_ren", {31'b0, imem_ren}, 32'h0);
    check_output("reset.imem_addr", imem_addr, RESET_PC);
    check_output("reset.instr_valid", {31'b0, instr_valid}, 32'h0);
    check_output("reset.instr", instr, NOP);
    check_output("reset.instr_pc", instr_pc, 32'h0);

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i], i);

    do_reset();
    m_q.delete();
    m_pc      = RESET_PC;
    m_pending = RESET_PC;
    m_drain   = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      nRST        = ($urandom_range(0, 99) != 0);
      imem_busy   = ($urandom_range(0, 99) < 30);
      stall       = ($urandom_range(0, 99) < 35);
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      imem_rdata  = 32'($urandom);
      #1;
      check_model(cyc);
      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the control unit. It issues word reads on the instruction generic bus, buffers returned words in a small FIFO with their PCs, and presents the head entry as `instr` to the control unit's `instr` input. Redirects from branch, jump, trap or `ifence` resolution flush the queue and restart fetch at a new PC. In-flight bus transactions are drained safely and never abandoned.

## Interface
- `DEPTH`, 4, queue entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0200, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, value driven on `instr` while the queue is empty.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  reset; one clock, reset is synchronous and active-low.
- `imem_ren`  out  1  bus read request.
- `imem_addr`  out  32  bus read address, word aligned.
- `imem_busy`  in  1  bus busy; a read completes in a cycle with `imem_ren && !imem_busy`.
- `imem_rdata`  in  32  read data, valid in the completing cycle.
- `redirect`  in  1  flush the queue and restart fetch.
- `redirect_pc`  in  32  restart target; bits [1:0] are ignored and forced to 0.
- `stall`  in  1  downstream does not accept the head entry this cycle.
- `instr`  out  32  head instruction, feeding the control unit `instr`.
- `instr_pc`  out  32  PC of the head instruction.
- `instr_valid`  out  1  head entry is valid.

## Operation
- Storage is `DEPTH` entries of {pc[31:0], instr[31:0]}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - `count` is log2(DEPTH)+1 bits.
- Outputs:
  - `instr_valid = (count != 0)`.
  - `instr`/`instr_pc` are the head entry when valid, otherwise `NOP_INSTR` / 32'h0.
  - Pop occurs when `instr_valid && !stall`.
- Only one bus transaction is outstanding at a time.
  - Once `imem_ren` rises, `imem_ren` and `imem_addr` hold stable until completion, regardless of `redirect`.
- State machine:
  - RUN:
    - `imem_ren = (count < DEPTH)`, `imem_addr = fetch_pc`.
    - On completion without redirect: push {fetch_pc, imem_rdata}, then `fetch_pc += 4`. The add wraps mod 2^32, so 32'hFFFF_FFFC becomes 0.
    - Space is guaranteed at completion, because `count` cannot grow while a request waits.
  - DRAIN: entered when `redirect` is asserted while a request is active and not completing (`imem_ren && imem_busy`).
    - `imem_ren`/`imem_addr` stay held.
    - On completion, the data is discarded, `fetch_pc <= pending_pc`, and the FSM goes to RUN.
    - A further `redirect` during DRAIN overwrites `pending_pc`; the latest redirect wins.
- Redirect in RUN with no active request, or with a request completing in that cycle:
  - Completing data is discarded.
  - `fetch_pc <= redirect_pc & ~3`; the FSM stays in RUN.
- Redirect always clears the queue in that cycle (pointers and count to 0). A simultaneous pop or push is ignored.
- Simultaneous push and pop without redirect: `count` is unchanged and both pointers advance.
- Reset (`!nRST` at an edge), including mid-transaction:
  - `fetch_pc = RESET_PC`, queue empty, FSM = RUN.
  - `imem_ren` is forced to 0 while `nRST` is low.
  - The bus is required to tolerate the abandoned request on reset only.

## Timing
- Reset values: `imem_ren=0`, `imem_addr=RESET_PC`, `instr_valid=0`, `instr=NOP_INSTR`, `instr_pc=0`.
- The first cycle with `nRST` high drives `imem_ren=1`, `imem_addr=RESET_PC`.
- Fetch latency: data completing in cycle t appears on `instr`/`instr_valid` in cycle t+1 (registered; no combinational path from `imem_rdata` to `instr`).
- With a zero-wait bus, throughput is one instruction per cycle.
- Redirect latency:
  - Redirect in cycle t with no active request gives `imem_addr=redirect_pc` with `imem_ren` in t+1.
  - With an active request, the new address is driven the cycle after the drained completion.
- `instr_valid` is 0 in the cycle after any redirect.
- Full queue: `imem_ren=0` in every cycle where `count==DEPTH` at cycle start. A pop in that cycle re-enables the request next cycle.

## Test plan
- Reset release, zero-wait bus, `stall=0`:
  - `imem_addr` sequence 0x200, 0x204, 0x208.
  - `instr_valid` first high one cycle after the 0x200 completion, with `instr_pc=0x200`.
- `stall=1` held for 10 cycles, zero-wait bus, `DEPTH=4`:
  - Exactly 4 completions occur, then `imem_ren=0`.
  - Deasserting `stall` pops 0x200 and restores `imem_ren=1` the next cycle.
- Redirect to 0x1003 with 2 entries queued and bus idle:
  - Next cycle `instr_valid=0` and `imem_addr=0x1000`.
  - The first delivered `instr_pc` is 0x1000.
- Redirect to 0x400 while `imem_busy=1` for 3 more cycles, then a second redirect to 0x800 during DRAIN:
  - `imem_addr` stays at its old value until completion.
  - The completing data is never delivered.
  - The next request address is 0x800.
- Redirect to 0xFFFF_FFFC:
  - Fetch addresses are 0xFFFF_FFFC then 0x0000_0000.
  - `instr_pc` values match those addresses in order.
- `nRST` low for one cycle mid-transaction with 3 entries queued:
  - Next cycle `instr_valid=0`, `instr=0x00000013`.
  - `imem_ren=1` at 0x200 the following cycle.
